locked_vector_checker: RTL and testbench
========================================

Name: locked_vector_checker

Overview:
- Parametrised self-checking harness wrapping a locked arithmetic core (e.g. float64_mul) behind an ap_start/ap_done interface.
- Walks NUM_VECTORS stored test vectors: reads operand A, operand B and expected Z; runs the core; compares the result; counts mismatches.
- Adds the following, all gated by the locking key:
  - a per-vector watchdog timeout;
  - first-failure index capture;
  - a stop-on-first-fail mode.

Parameters:
- DATA_W, 64, operand/result width.
- NUM_VECTORS, 20, vectors per run (1..2**ADDR_W).
- ADDR_W, 5, vector memory address width.
- CNT_W, 8, mismatch counter width (saturating).
- TIMEOUT, 1024, max cycles waiting for core done per vector (>=2).
- KEY_W, 64, working key width.
- LOCK_KEY, 64'h0, correct key value.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start a run.
- stop_on_fail  in  1  mode; sampled at run start.
- ap_done  out  1  one-cycle pulse at run end.
- ap_idle  out  1  high in IDLE with ap_start=0.
- ap_ready  out  1  equals ap_done.
- ap_return  out  CNT_W  mismatch count.
- fail_valid  out  1  a mismatch or timeout occurred this run.
- fail_idx  out  ADDR_W  index of first failing vector.
- timeout_err  out  1  some vector hit TIMEOUT.
- vec_addr  out  ADDR_W  vector memory address.
- vec_ce  out  1  vector memory read enable.
- vec_a_q  in  DATA_W  operand A (1-cycle read latency).
- vec_b_q  in  DATA_W  operand B.
- vec_z_q  in  DATA_W  expected result.
- dut_start  out  1  core start.
- dut_ready  in  1  core accepted start.
- dut_done  in  1  core result valid.
- dut_a  out  DATA_W  registered operand A.
- dut_b  out  DATA_W  registered operand B.
- dut_result  in  DATA_W  core result.
- working_key  in  KEY_W  locking key; also forwarded unmodified to the core by the parent.

Behaviour:

Reset (ap_rst_n=0, any time):
- State → IDLE.
- All outputs 0, counters 0, dut_a/dut_b 0.
- A reset mid-run abandons the run; no ap_done is issued.

Key check:
- key_ok = (working_key == LOCK_KEY), combinational.

States:

IDLE:
- On ap_start=1: idx←0, ap_return←0, fail_valid←0, fail_idx←0, timeout_err←0; latch stop_on_fail.
- Go to FETCH.

FETCH:
- vec_ce=1, vec_addr=idx.
- Go to LATCH.

LATCH:
- dut_a←vec_a_q, dut_b←vec_b_q, z_exp←vec_z_q.
- Go to START.

START:
- dut_start=1. It stays high through WAIT until dut_ready is sampled 1, then drops.
- wd←0.
- Go to WAIT.

WAIT:
- wd increments each cycle.
- If dut_done=1: capture dut_result, go to CHECK.
- Else if wd==TIMEOUT-1: set timeout_err, treat the vector as a mismatch, go to CHECK. dut_start is forced low.
- dut_done takes priority over timeout in the same cycle.

CHECK:
- mism = (result != z_exp) OR timed-out.
- If key_ok=0, mism is inverted.
- If mism:
  - ap_return increments, saturating at 2**CNT_W-1;
  - if fail_valid=0, then fail_idx←idx and fail_valid←1.
- Next state:
  - if idx==NUM_VECTORS-1, or (stop_on_fail and mism): go to DONE;
  - else idx←idx+1 and go to FETCH.

DONE:
- ap_done=ap_ready=1 for one cycle.
- Go to IDLE.

Locking:
- With key_ok=0, additionally LATCH→CHECK directly, skipping the core (result=0).
- Without the correct key the count is meaningless; behaviour remains deterministic.

General:
- ap_return, fail_idx, fail_valid and timeout_err hold their values in IDLE until the next start.
- ap_start is ignored outside IDLE.
- Latency with the correct key: per vector = 4 + core latency (cycles from dut_start to dut_done). Run = sum over vectors + 2.

Test Plan:
1. Correct key; 20 vectors where core result == z for all; 3-cycle core → ap_return=0, fail_valid=0, ap_done pulse exactly 1 cycle at cycle 2+20×7.
2. Correct key; vectors 4 and 11 wrong; stop_on_fail=0 → ap_return=2, fail_idx=4, fail_valid=1.
3. Same stimulus as 2 with stop_on_fail=1 → ap_return=1, fail_idx=4, ap_done after vector 4, vec_addr never exceeds 4.
4. Core never asserts dut_done on vector 7; TIMEOUT=16 → timeout_err=1, ap_return=1, fail_idx=7, run completes.
5. Wrong key (LOCK_KEY^1), all-matching vectors → ap_return=20, dut_start never asserted.
6. ap_rst_n pulsed low in WAIT of vector 5 → all outputs 0 immediately, no ap_done; a new ap_start gives a clean result identical to scenario 1.

Source files
------------

// File: rtl/locked_vector_checker.sv
// Self-checking harness that runs stored vectors through a locked core.
// Ports: ap_* control, vec_* vector memory, dut_* core handshake, working_key.
module locked_vector_checker #(
    parameter int                DATA_W      = 64,
    parameter int                NUM_VECTORS = 20,
    parameter int                ADDR_W      = 5,
    parameter int                CNT_W       = 8,
    parameter int                TIMEOUT     = 1024,
    parameter int                KEY_W       = 64,
    parameter logic [KEY_W-1:0]  LOCK_KEY    = '0
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              stop_on_fail,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [CNT_W-1:0]  ap_return,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_idx,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_ce,
    input  logic [DATA_W-1:0] vec_a_q,
    input  logic [DATA_W-1:0] vec_b_q,
    input  logic [DATA_W-1:0] vec_z_q,
    output logic              dut_start,
    input  logic              dut_ready,
    input  logic              dut_done,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    input  logic [DATA_W-1:0] dut_result,
    input  logic [KEY_W-1:0]  working_key
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_START, S_WAIT, S_CHECK, S_DONE
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NUM_VECTORS - 1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   z_exp;
    logic [DATA_W-1:0]   res;
    logic [WD_W-1:0]     wd;
    logic                sof;
    logic                timed_out;
    logic                skipped;
    logic                key_ok;
    logic                raw_mism;
    logic                mism;

    assign key_ok = (working_key == LOCK_KEY);

    // A skipped vector compares as equal, so a wrong key flags every vector.
    assign raw_mism = skipped ? 1'b0 : ((res != z_exp) || timed_out);
    assign mism     = key_ok ? raw_mism : !raw_mism;

    assign ap_ready = ap_done;
    assign ap_idle  = ap_rst_n && (state == S_IDLE) && !ap_start;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            z_exp       <= '0;
            res         <= '0;
            wd          <= '0;
            sof         <= 1'b0;
            timed_out   <= 1'b0;
            skipped     <= 1'b0;
            ap_done     <= 1'b0;
            ap_return   <= '0;
            fail_valid  <= 1'b0;
            fail_idx    <= '0;
            timeout_err <= 1'b0;
            vec_addr    <= '0;
            vec_ce      <= 1'b0;
            dut_start   <= 1'b0;
            dut_a       <= '0;
            dut_b       <= '0;
        end else begin
            ap_done <= 1'b0;
            vec_ce  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        idx         <= '0;
                        ap_return   <= '0;
                        fail_valid  <= 1'b0;
                        fail_idx    <= '0;
                        timeout_err <= 1'b0;
                        sof         <= stop_on_fail;
                        vec_addr    <= '0;
                        vec_ce      <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    dut_a     <= vec_a_q;
                    dut_b     <= vec_b_q;
                    z_exp     <= vec_z_q;
                    res       <= '0;
                    timed_out <= 1'b0;
                    if (key_ok) begin
                        skipped   <= 1'b0;
                        dut_start <= 1'b1;
                        state     <= S_START;
                    end else begin
                        skipped <= 1'b1;
                        state   <= S_CHECK;
                    end
                end
                S_START: begin
                    wd <= '0;
                    if (dut_ready) dut_start <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wd <= wd + 1'b1;
                    if (dut_ready) dut_start <= 1'b0;
                    if (dut_done) begin
                        res   <= dut_result;
                        state <= S_CHECK;
                    end else if (wd == WD_MAX) begin
                        timed_out   <= 1'b1;
                        timeout_err <= 1'b1;
                        dut_start   <= 1'b0;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mism) begin
                        if (ap_return != CNT_MAX)
                            ap_return <= ap_return + 1'b1;
                        if (!fail_valid) begin
                            fail_idx   <= idx;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (idx == LAST || (sof && mism)) begin
                        ap_done <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        vec_addr <= idx + 1'b1;
                        vec_ce   <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_locked_vector_checker.sv
// Directed bench for locked_vector_checker with a 3-cycle core model.
// Ports: drives all DUT inputs, models vector memory and the locked core.
module tb_locked_vector_checker;

    localparam logic [63:0] KEY = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        stop_on_fail = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [7:0]  ap_return;
    logic        fail_valid;
    logic [4:0]  fail_idx;
    logic        timeout_err;
    logic [4:0]  vec_addr;
    logic        vec_ce;
    logic [63:0] a_q, b_q, z_q;
    logic        dut_start;
    logic        dut_ready = 1'b1;
    logic        dut_done;
    logic [63:0] dut_a, dut_b, dut_result;
    logic [63:0] working_key = KEY;

    logic [63:0] mem_a [32];
    logic [63:0] mem_b [32];
    logic [63:0] mem_z [32];

    int bad0 = -1;
    int bad1 = -1;
    int hang = -1;
    int cnt;
    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    int guard;

    logic       clr = 1'b0;
    int         starts;
    int         done_hi;
    logic [4:0] max_addr;

    always #5 clk = ~clk;

    locked_vector_checker #(
        .DATA_W(64), .NUM_VECTORS(20), .ADDR_W(5), .CNT_W(8),
        .TIMEOUT(16), .KEY_W(64), .LOCK_KEY(KEY)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
        .stop_on_fail(stop_on_fail), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready),
        .ap_return(ap_return), .fail_valid(fail_valid),
        .fail_idx(fail_idx), .timeout_err(timeout_err),
        .vec_addr(vec_addr), .vec_ce(vec_ce),
        .vec_a_q(a_q), .vec_b_q(b_q), .vec_z_q(z_q),
        .dut_start(dut_start), .dut_ready(dut_ready),
        .dut_done(dut_done), .dut_a(dut_a), .dut_b(dut_b),
        .dut_result(dut_result), .working_key(working_key)
    );

    function automatic logic is_vec(input int k);
        return (k >= 0) && (dut_a == mem_a[k]);
    endfunction

    always @(posedge clk) begin
        if (vec_ce) begin
            a_q <= mem_a[vec_addr];
            b_q <= mem_b[vec_addr];
            z_q <= mem_z[vec_addr];
        end
    end

    // Core: result valid 3 cycles after the accepting start cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 0;
            dut_done   <= 1'b0;
            dut_result <= '0;
        end else begin
            if (dut_done) dut_done <= 1'b0;
            if (dut_start && dut_ready) begin
                cnt <= is_vec(hang) ? 0 : 2;
                dut_result <= dut_a + dut_b
                            + ((is_vec(bad0) || is_vec(bad1)) ? 64'd1 : 64'd0);
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end else if (cnt == 1) begin
                dut_done <= 1'b1;
                cnt      <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (clr) begin
            starts   <= 0;
            done_hi  <= 0;
            max_addr <= '0;
        end else begin
            if (dut_start) starts <= starts + 1;
            if (ap_done && ap_ready) done_hi <= done_hi + 1;
            if (vec_ce && vec_addr > max_addr) max_addr <= vec_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic sof);
        @(negedge clk);
        clr = 1'b1;
        ap_start = 1'b1;
        stop_on_fail = sof;
        @(negedge clk);
        clr = 1'b0;
        ap_start = 1'b0;
        cyc = 1;
        while (!ap_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!ap_done) chk("run_timeout", 64'd0, 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 64'(i + 1) * 64'h0001_0003_0005_0007;
            mem_b[i] = 64'h1111 * 64'(i + 3);
            mem_z[i] = mem_a[i] + mem_b[i];
        end
        #12;
        chk("rst_return", 64'(ap_return), 64'd0);
        chk("rst_flags", {fail_valid, timeout_err, ap_done, vec_ce,
                          dut_start, ap_idle}, 64'd0);
        chk("rst_dut_a", dut_a | dut_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 64'(ap_idle), 64'd1);

        run(1'b0);
        chk("s1_return", 64'(ap_return), 64'd0);
        chk("s1_valid", 64'(fail_valid), 64'd0);
        chk("s1_cycles", 64'(cyc), 64'd141);
        chk("s1_done_width", 64'(done_hi), 64'd1);
        chk("s1_timeout", 64'(timeout_err), 64'd0);

        bad0 = 4;
        bad1 = 11;
        run(1'b0);
        chk("s2_return", 64'(ap_return), 64'd2);
        chk("s2_idx", 64'(fail_idx), 64'd4);
        chk("s2_valid", 64'(fail_valid), 64'd1);

        run(1'b1);
        chk("s3_return", 64'(ap_return), 64'd1);
        chk("s3_idx", 64'(fail_idx), 64'd4);
        chk("s3_cycles", 64'(cyc), 64'd36);
        chk("s3_max_addr", 64'(max_addr), 64'd4);

        bad0 = -1;
        bad1 = -1;
        hang = 7;
        run(1'b0);
        chk("s4_timeout", 64'(timeout_err), 64'd1);
        chk("s4_return", 64'(ap_return), 64'd1);
        chk("s4_idx", 64'(fail_idx), 64'd7);
        chk("s4_cycles", 64'(cyc), 64'd154);
        hang = -1;

        working_key = KEY ^ 64'd1;
        run(1'b0);
        chk("s5_return", 64'(ap_return), 64'd20);
        chk("s5_starts", 64'(starts), 64'd0);
        chk("s5_cycles", 64'(cyc), 64'd61);
        working_key = KEY;

        bad0 = 2;
        @(negedge clk);
        clr = 1'b1;
        ap_start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ap_start = 1'b0;
        guard = 0;
        while (!(dut_start && vec_addr == 5'd5) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("s6_reach_v5", 64'(guard < 500), 64'd1);
        chk("s6_pre_valid", 64'(fail_valid), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_rst_return", 64'(ap_return), 64'd0);
        chk("s6_rst_flags", {fail_valid, timeout_err, ap_done, vec_ce,
                             dut_start, 5'(fail_idx)}, 64'd0);
        chk("s6_rst_addr", 64'(vec_addr), 64'd0);
        chk("s6_rst_dut_a", dut_a | dut_b, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_no_done", 64'(done_hi), 64'd0);
        bad0 = -1;
        run(1'b0);
        chk("s6_return", 64'(ap_return), 64'd0);
        chk("s6_valid", 64'(fail_valid), 64'd0);
        chk("s6_cycles", 64'(cyc), 64'd141);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
